ws281x_rx: RTL and testbench

//  Decodes a WS281x single-wire NRZ stream (the output of ws281x_drv) back into 24-bit GRB words.
//  - Used for loopback checking of the RGB LED drive path.
//  - Used to monitor the far end of the LED daisy chain.
//  - Sits beside ws281x_drv in the clk_sys domain.

---
 rtl/ws281x_pkg.sv | 17 +
 rtl/prim_flop_2sync.sv | 28 ++
 rtl/ws281x_rx_obuf.sv | 48 ++++
 rtl/ws281x_rx.sv | 182 ++++++++++++++++++
 tb/tb_ws281x_rx.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ws281x_pkg.sv
// Shared WS281x definitions for the LED drive and receive paths.
// Timing constants are clk_sys cycles at 50 MHz.
package ws281x_pkg;

   localparam int unsigned T0H    = 20;
   localparam int unsigned T1H    = 40;
   localparam int unsigned TBIT   = 63;
   localparam int unsigned TRESET = 2500;

   typedef enum logic [1:0] {
      WAIT_GAP,
      IDLE,
      HIGH,
      LOW
   } ws281x_rx_state_e;

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchroniser for asynchronous inputs.
// Ports: clk_sys/rst_sys_n clock and async low reset, i_d async in, o_q synced out.
module prim_flop_2sync #(
   parameter int unsigned Width      = 1,
   parameter logic        ResetValue = 1'b0
) (
   input  logic             clk_sys,
   input  logic             rst_sys_n,
   input  logic [Width-1:0] i_d,
   output logic [Width-1:0] o_q
);

   logic [Width-1:0] r_s1;
   logic [Width-1:0] r_s2;

   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         r_s1 <= {Width{ResetValue}};
         r_s2 <= {Width{ResetValue}};
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
      end
   end

   assign o_q = r_s2;

endmodule

// File: rtl/ws281x_rx_obuf.sv
// One-entry valid/ready output register for decoded words, with drop detect.
// Ports: i_push/i_word new word, i_ready consumer, o_data/o_valid held word,
// o_drop pulse when a word is lost, o_overflow sticky loss flag.
module ws281x_rx_obuf #(
   parameter int unsigned DataWidth = 24
) (
   input  logic                 clk_sys,
   input  logic                 rst_sys_n,
   input  logic                 i_push,
   input  logic [DataWidth-1:0] i_word,
   input  logic                 i_ready,
   output logic [DataWidth-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_drop,
   output logic                 o_overflow
);

   logic [DataWidth-1:0] r_data;
   logic                 r_valid;
   logic                 r_ovf;
   logic                 w_free;

   // Slot is usable if empty or being drained this cycle.
   assign w_free = !r_valid || i_ready;
   assign o_drop = i_push && !w_free;

   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (i_push) begin
         if (w_free) begin
            r_data  <= i_word;
            r_valid <= 1'b1;
         end else begin
            r_ovf <= 1'b1;
         end
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_data     = r_data;
   assign o_valid    = r_valid;
   assign o_overflow = r_ovf;

endmodule

// File: rtl/ws281x_rx.sv
// WS281x NRZ receiver: decodes high-time coded bits into GRB words.
// Ports: din_i pad in, en_i enable, data_o/data_valid_o/data_ready_i word port,
// latch_o frame gap pulse, err_o error pulse, overflow_o sticky, idle_o.
module ws281x_rx
   import ws281x_pkg::*;
#(
   parameter int unsigned DataWidth     = 24,
   parameter int unsigned ThreshCycles  = 30,
   parameter int unsigned MaxHighCycles = 75,
   parameter int unsigned ResetCycles   = TRESET
) (
   input  logic                 clk_sys,
   input  logic                 rst_sys_n,
   input  logic                 en_i,
   input  logic                 din_i,
   output logic [DataWidth-1:0] data_o,
   output logic                 data_valid_o,
   input  logic                 data_ready_i,
   output logic                 latch_o,
   output logic                 err_o,
   output logic                 overflow_o,
   output logic                 idle_o
);

   localparam int unsigned CW = $clog2(ResetCycles + 1);
   localparam int unsigned BW = $clog2(DataWidth + 1);

   localparam logic [CW-1:0] C_ONE  = CW'(1);
   localparam logic [CW-1:0] C_THR  = CW'(ThreshCycles);
   localparam logic [CW-1:0] C_MAXH = CW'(MaxHighCycles);
   localparam logic [CW-1:0] C_RST  = CW'(ResetCycles);
   localparam logic [BW-1:0] C_LAST = BW'(DataWidth - 1);

   ws281x_rx_state_e r_state, w_state_nxt;

   logic                 w_din_s;
   logic                 r_din_d;
   logic                 w_rise;
   logic                 w_fall;
   logic [CW-1:0]        r_high_cnt, w_high_nxt;
   logic [CW-1:0]        r_low_cnt, w_low_nxt;
   logic [BW-1:0]        r_bit_cnt, w_bit_nxt;
   logic [DataWidth-1:0] r_shift, w_shift_nxt;
   logic [DataWidth-1:0] w_word;
   logic                 w_push;
   logic                 w_drop;
   logic                 w_latch_nxt;
   logic                 w_err_nxt;
   logic                 r_latch;
   logic                 r_err;

   prim_flop_2sync #(
      .Width      (1),
      .ResetValue (1'b0)
   ) u_sync (
      .clk_sys   (clk_sys),
      .rst_sys_n (rst_sys_n),
      .i_d       (din_i),
      .o_q       (w_din_s)
   );

   assign w_rise = w_din_s && !r_din_d;
   assign w_fall = !w_din_s && r_din_d;

   always_comb begin
      w_state_nxt = r_state;
      w_high_nxt  = r_high_cnt;
      w_low_nxt   = r_low_cnt;
      w_bit_nxt   = r_bit_cnt;
      w_shift_nxt = r_shift;
      w_word      = {r_shift[DataWidth-2:0], (r_high_cnt >= C_THR)};
      w_push      = 1'b0;
      w_latch_nxt = 1'b0;
      w_err_nxt   = 1'b0;
      if (!en_i) begin
         w_state_nxt = WAIT_GAP;
         w_high_nxt  = '0;
         w_low_nxt   = '0;
         w_bit_nxt   = '0;
         w_shift_nxt = '0;
      end else begin
         unique case (r_state)
            WAIT_GAP: begin
               if (w_din_s) begin
                  w_low_nxt = '0;
               end else if (r_low_cnt == C_RST) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_low_nxt = r_low_cnt + C_ONE;
               end
            end
            IDLE: begin
               if (w_rise) begin
                  w_state_nxt = HIGH;
                  w_high_nxt  = C_ONE;
               end
            end
            HIGH: begin
               if (r_high_cnt == C_MAXH) begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = WAIT_GAP;
                  w_low_nxt   = '0;
                  w_bit_nxt   = '0;
                  w_shift_nxt = '0;
               end else if (w_fall) begin
                  w_state_nxt = LOW;
                  w_low_nxt   = C_ONE;
                  if (r_bit_cnt == C_LAST) begin
                     w_push      = 1'b1;
                     w_bit_nxt   = '0;
                     w_shift_nxt = '0;
                  end else begin
                     w_bit_nxt   = r_bit_cnt + BW'(1);
                     w_shift_nxt = w_word;
                  end
               end else if (r_high_cnt != '1) begin
                  w_high_nxt = r_high_cnt + C_ONE;
               end
            end
            LOW: begin
               if (w_rise) begin
                  w_state_nxt = HIGH;
                  w_high_nxt  = C_ONE;
               end else if (r_low_cnt == C_RST) begin
                  w_state_nxt = IDLE;
                  // A gap inside a word is a truncated frame, not a latch.
                  if (r_bit_cnt == '0) begin
                     w_latch_nxt = 1'b1;
                  end else begin
                     w_err_nxt   = 1'b1;
                     w_bit_nxt   = '0;
                     w_shift_nxt = '0;
                  end
               end else begin
                  w_low_nxt = r_low_cnt + C_ONE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         r_state    <= WAIT_GAP;
         r_din_d    <= 1'b0;
         r_high_cnt <= '0;
         r_low_cnt  <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_latch    <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_din_d    <= w_din_s;
         r_high_cnt <= w_high_nxt;
         r_low_cnt  <= w_low_nxt;
         r_bit_cnt  <= w_bit_nxt;
         r_shift    <= w_shift_nxt;
         r_latch    <= w_latch_nxt;
         r_err      <= w_err_nxt || w_drop;
      end
   end

   ws281x_rx_obuf #(
      .DataWidth (DataWidth)
   ) u_obuf (
      .clk_sys    (clk_sys),
      .rst_sys_n  (rst_sys_n),
      .i_push     (w_push),
      .i_word     (w_word),
      .i_ready    (data_ready_i),
      .o_data     (data_o),
      .o_valid    (data_valid_o),
      .o_drop     (w_drop),
      .o_overflow (overflow_o)
   );

   assign latch_o = r_latch;
   assign err_o   = r_err;
   assign idle_o  = (r_state == WAIT_GAP) || (r_state == IDLE);

endmodule

// File: tb/tb_ws281x_rx.sv
// Self-checking bench for ws281x_rx.
// Bits are modelled purely from high time: >= 30 cycles is '1'.
module tb_ws281x_rx;

   localparam int TH = 30;

   logic        clk_sys      = 1'b0;
   logic        rst_sys_n    = 1'b0;
   logic        en_i         = 1'b1;
   logic        din_i        = 1'b0;
   logic        data_ready_i = 1'b0;
   logic [23:0] data_o;
   logic        data_valid_o;
   logic        latch_o;
   logic        err_o;
   logic        overflow_o;
   logic        idle_o;

   ws281x_rx dut (
      .clk_sys      (clk_sys),
      .rst_sys_n    (rst_sys_n),
      .en_i         (en_i),
      .din_i        (din_i),
      .data_o       (data_o),
      .data_valid_o (data_valid_o),
      .data_ready_i (data_ready_i),
      .latch_o      (latch_o),
      .err_o        (err_o),
      .overflow_o   (overflow_o),
      .idle_o       (idle_o)
   );

   always #5 clk_sys = ~clk_sys;

   int total = 0;
   int bad   = 0;

   int          n_latch  = 0;
   int          n_err    = 0;
   int          n_unst   = 0;
   int          rdy_mode = 1;
   logic [23:0] q_got[$];
   logic        pv = 1'b0;
   logic [23:0] pd = '0;

   // Consumer and pulse monitor: a word is taken when it was valid
   // before the edge and ready was high across that edge.
   always @(negedge clk_sys) begin
      if (!rst_sys_n) begin
         pv = 1'b0;
      end else begin
         if (latch_o) n_latch++;
         if (err_o) n_err++;
         if (pv && data_ready_i) q_got.push_back(pd);
         else if (pv && (!data_valid_o || data_o !== pd)) n_unst++;
         pv = data_valid_o;
         pd = data_o;
      end
      case (rdy_mode)
         0:       data_ready_i = 1'b0;
         1:       data_ready_i = 1'b1;
         default: data_ready_i = 1'($urandom_range(0, 1));
      endcase
   end

   int b_latch, b_err, b_got;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      b_latch = n_latch;
      b_err   = n_err;
      b_got   = q_got.size();
   endtask

   task automatic pulse(input int hi, input int lo);
      din_i = 1'b1;
      repeat (hi) @(negedge clk_sys);
      din_i = 1'b0;
      repeat (lo) @(negedge clk_sys);
   endtask

   task automatic gap(input int n);
      din_i = 1'b0;
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic send_fixed(input logic [23:0] w);
      for (int i = 23; i >= 0; i--) begin
         if (w[i]) pulse(40, 22);
         else pulse(20, 42);
      end
   endtask

   task automatic send_bits(input int n, output logic [23:0] exp);
      int hi;
      exp = '0;
      for (int i = 0; i < n; i++) begin
         hi  = int'($urandom_range(5, 74));
         exp = {exp[22:0], (hi >= TH)};
         pulse(hi, int'($urandom_range(8, 40)));
      end
   endtask

   task automatic chk_frame(input string tag, input logic [23:0] ew[$],
                            input int el, input int ee);
      chk({tag, " words"}, q_got.size() - b_got, ew.size());
      for (int i = 0; i < ew.size(); i++) begin
         if (b_got + i < q_got.size())
            chk({tag, " word"}, q_got[b_got+i], ew[i]);
      end
      chk({tag, " latch"}, n_latch - b_latch, el);
      chk({tag, " err"}, n_err - b_err, ee);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " data"}, data_o, 0);
      chk({tag, " valid"}, data_valid_o, 0);
      chk({tag, " latch"}, latch_o, 0);
      chk({tag, " err"}, err_o, 0);
      chk({tag, " ovf"}, overflow_o, 0);
      chk({tag, " idle"}, idle_o, 1);
   endtask

   initial begin
      logic [23:0] ew[$];
      logic [23:0] w;
      logic [23:0] w0;
      int          hi;

      repeat (3) @(negedge clk_sys);
      chk_reset("rst");
      rst_sys_n = 1'b1;

      // Fixed-timing single word and frame latch.
      rdy_mode = 1;
      gap(2600);
      snap();
      send_fixed(24'hA50F3C);
      gap(2600);
      ew = '{24'hA50F3C};
      chk_frame("t1", ew, 1, 0);

      // Two frames under random ready stalls.
      rdy_mode = 2;
      snap();
      ew = '{24'h000000, 24'hFFFFFF, 24'h123456, 24'h800001};
      foreach (ew[i]) send_fixed(ew[i]);
      gap(2600);
      for (int i = 0; i < 3; i++) begin
         send_bits(24, w);
         ew.push_back(w);
      end
      gap(2600);
      chk_frame("t2", ew, 2, 0);
      chk("t2 ovf", overflow_o, 0);

      // Consumer stalled: second word dropped.
      rdy_mode = 0;
      repeat (2) @(negedge clk_sys);
      snap();
      send_fixed(24'h5A5A01);
      send_fixed(24'h0F0F0E);
      gap(30);
      chk("t3 valid", data_valid_o, 1);
      chk("t3 data", data_o, 24'h5A5A01);
      chk("t3 err", n_err - b_err, 1);
      chk("t3 ovf", overflow_o, 1);
      rdy_mode = 1;
      gap(2600);
      ew = '{24'h5A5A01};
      chk_frame("t3", ew, 1, 1);
      chk("t3 valid2", data_valid_o, 0);
      chk("t3 ovf sticky", overflow_o, 1);

      // Over-long high mid-word.
      snap();
      send_bits(10, w);
      pulse(80, 20);
      chk("t4 err", n_err - b_err, 1);
      chk("t4 idle", idle_o, 1);
      gap(2600);
      send_bits(24, w);
      gap(2600);
      ew = '{w};
      chk_frame("t4", ew, 1, 1);

      // Truncated word followed by a gap.
      snap();
      send_bits(10, w);
      gap(2600);
      ew.delete();
      chk_frame("t5a", ew, 0, 1);
      snap();
      send_bits(24, w);
      gap(2600);
      ew = '{w};
      chk_frame("t5b", ew, 1, 0);

      // Threshold and max-high boundaries.
      snap();
      w0 = '0;
      for (int i = 0; i < 24; i++) begin
         hi = (i % 3 == 0) ? 29 : ((i % 3 == 1) ? 30 : 74);
         w0 = {w0[22:0], (hi >= TH)};
         pulse(hi, 25);
      end
      gap(2600);
      ew = '{w0};
      chk_frame("t6 bound", ew, 1, 0);

      // Enable dropped mid-word.
      snap();
      send_bits(8, w);
      en_i = 1'b0;
      repeat (2) @(negedge clk_sys);
      chk("t6 en idle", idle_o, 1);
      en_i = 1'b1;
      gap(2600);
      ew.delete();
      chk_frame("t6 en", ew, 0, 0);

      // Async reset mid-word, then resync and decode.
      send_bits(12, w);
      #2 rst_sys_n = 1'b0;
      #1 chk_reset("t6 midrst");
      @(negedge clk_sys);
      rst_sys_n = 1'b1;
      gap(2600);
      snap();
      send_bits(24, w);
      gap(2600);
      ew = '{w};
      chk_frame("t6 post", ew, 1, 0);
      chk("t6 ovf", overflow_o, 0);

      chk("stable", n_unst, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
